// File: rtl/lib_mularb2_if.sv
// ----------------------------------------------------------------------------
// lib_mularb2_if
// Bundles the two requester channels and the shared-multiplier channel used
// by lib_mularb2.
//   req{0,1}_in0/in1/val/rdy : operand request channel from each requester
//   rsp{0,1}_out/val/rdy     : product response channel to each requester
//   mul_req_in0/in1/val/rdy  : operand request channel to the multiplier
//   mul_rsp_out/val/rdy      : product response channel from the multiplier
// Modports:
//   master : the surroundings (requesters + multiplier)
//   slave  : the arbiter itself
// ----------------------------------------------------------------------------
interface lib_mularb2_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0]   req0_in0, req0_in1;
  logic                req0_val, req0_rdy;
  logic [2*DATA_W-1:0] rsp0_out;
  logic                rsp0_val, rsp0_rdy;

  logic [DATA_W-1:0]   req1_in0, req1_in1;
  logic                req1_val, req1_rdy;
  logic [2*DATA_W-1:0] rsp1_out;
  logic                rsp1_val, rsp1_rdy;

  logic [DATA_W-1:0]   mul_req_in0, mul_req_in1;
  logic                mul_req_val, mul_req_rdy;
  logic [2*DATA_W-1:0] mul_rsp_out;
  logic                mul_rsp_val, mul_rsp_rdy;

  modport master (
    output req0_in0, req0_in1, req0_val, rsp0_rdy,
    output req1_in0, req1_in1, req1_val, rsp1_rdy,
    output mul_req_rdy, mul_rsp_out, mul_rsp_val,
    input  req0_rdy, rsp0_out, rsp0_val,
    input  req1_rdy, rsp1_out, rsp1_val,
    input  mul_req_in0, mul_req_in1, mul_req_val, mul_rsp_rdy
  );

  modport slave (
    input  req0_in0, req0_in1, req0_val, rsp0_rdy,
    input  req1_in0, req1_in1, req1_val, rsp1_rdy,
    input  mul_req_rdy, mul_rsp_out, mul_rsp_val,
    output req0_rdy, rsp0_out, rsp0_val,
    output req1_rdy, rsp1_out, rsp1_val,
    output mul_req_in0, mul_req_in1, mul_req_val, mul_rsp_rdy
  );
endinterface

// File: rtl/lib_mularb2.sv
// ----------------------------------------------------------------------------
// lib_mularb2
// Two-requester round-robin arbiter/sequencer in front of one shared
// DATA_W x DATA_W -> 2*DATA_W multiplier. One operation is in flight at a
// time; its product is returned only to the requester that issued it.
// Ports:
//   clk    : clock
//   reset  : asynchronous active-low reset (0 = in reset)
//   bus    : lib_mularb2_if.slave, requester and multiplier channels
//   perf_cnt0/perf_cnt1 : response handshake counters, present only when
//            MULARB_PERF_CNT_EN is defined
// Sequence: IDLE (arbitrate/accept) -> ISSUE (drive multiplier) ->
//           WAIT (take product) -> RESP (return to owner) -> IDLE
// ----------------------------------------------------------------------------
module lib_mularb2 #(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  lib_mularb2_if.slave bus
`ifdef MULARB_PERF_CNT_EN
  ,
  output logic [31:0]  perf_cnt0,
  output logic [31:0]  perf_cnt1
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   op0_q, op1_q;
  logic [2*DATA_W-1:0] result_q;
  logic                owner_q;
  logic                last_grant_q;

  logic                grant;
  logic                any_val;
  logic                owner_rsp_rdy;
  logic                rsp0_val, rsp1_val;

  // Round robin: a lone requester always wins; under contention the one
  // that did not win last time goes next.
  // NOTE: grant gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_val && bus.req1_val) grant = ~last_grant_q;
    else                              grant = bus.req1_val;
  end

  assign any_val = bus.req0_val || bus.req1_val;

  // Gated with reset so neither requester sees an accept while held in reset.
  assign bus.req0_rdy = reset && (state == S_IDLE) && bus.req0_val && !grant;
  assign bus.req1_rdy = reset && (state == S_IDLE) && bus.req1_val &&  grant;

  assign bus.mul_req_val = (state == S_ISSUE);
  assign bus.mul_req_in0 = op0_q;
  assign bus.mul_req_in1 = op1_q;
  assign bus.mul_rsp_rdy = (state == S_WAIT);

  assign rsp0_val     = (state == S_RESP) && !owner_q;
  assign rsp1_val     = (state == S_RESP) &&  owner_q;
  assign bus.rsp0_val = rsp0_val;
  assign bus.rsp1_val = rsp1_val;
  // The non-owner always reads zero, so a product never leaks across.
  assign bus.rsp0_out = owner_q ? '0 : result_q;
  assign bus.rsp1_out = owner_q ? result_q : '0;

  assign owner_rsp_rdy = owner_q ? bus.rsp1_rdy : bus.rsp0_rdy;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: operand/result/owner registers are reset as well, so the data
  // outputs read zero straight out of reset rather than X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      op0_q        <= '0;
      op1_q        <= '0;
      result_q     <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;  // requester 0 wins the first contention
    end else begin
      case (state)
        S_IDLE: begin
          // any_val implies the granted requester sees rdy this cycle.
          if (any_val) begin
            op0_q        <= grant ? bus.req1_in0 : bus.req0_in0;
            op1_q        <= grant ? bus.req1_in1 : bus.req0_in1;
            owner_q      <= grant;
            last_grant_q <= grant;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.mul_req_rdy) state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mul_rsp_val) begin
            result_q <= bus.mul_rsp_out;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (owner_rsp_rdy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MULARB_PERF_CNT_EN
  // Completed-response counters; natural 32-bit wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cnt0 <= '0;
      perf_cnt1 <= '0;
    end else begin
      if (rsp0_val && bus.rsp0_rdy) perf_cnt0 <= perf_cnt0 + 32'd1;
      if (rsp1_val && bus.rsp1_rdy) perf_cnt1 <= perf_cnt1 + 32'd1;
    end
  end
`endif

endmodule
